// File: rtl/core_intf_trace_rom.sv
// Purpose: fixed write-then-readback instruction trace for one cache replay node, plus a sticky out-of-range monitor.
// Latency: data_o is combinational from addr_i (zero cycles); error_o is registered (one edge).
// Backpressure: none; the replay node owns pacing and simply holds addr_i while it waits.
//
// Ports:
//   clk_i    - clock (single domain)
//   reset_i  - synchronous active-high reset, clears error_o only
//   addr_i   - entry index from the replay node
//   data_o   - {op[3:0], payload[68:0]} at addr_i
//   error_o  - sticky, set by any fetch of an index past the done entry
module core_intf_trace_rom #(
    parameter int width_p      = 73,
    parameter int addr_width_p = 15,
    parameter int trace_id_p   = 0
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [addr_width_p-1:0] addr_i,
    output logic [width_p-1:0]      data_o,
    output logic                    error_o
);

    if (trace_id_p < 0 || trace_id_p > 2) begin : g_bad_trace_id
        $error("core_intf_trace_rom: trace_id_p must be 0, 1 or 2");
    end
    if (width_p != 73) begin : g_bad_width
        $error("core_intf_trace_rom: width_p must be 73");
    end
    if (addr_width_p < 5) begin : g_bad_addr_width
        $error("core_intf_trace_rom: addr_width_p must hold index 24");
    end

    localparam logic [3:0] op_send_c = 4'h1;
    localparam logic [3:0] op_recv_c = 4'h2;
    localparam logic [3:0] op_done_c = 4'h3;

    // Each trace owns its own 4 KB region so concurrent caches never share lines.
    localparam logic [31:0] base_c = 32'(trace_id_p) << 12;
    localparam logic [31:0] tag_c  = 32'hC0DE_0000 | (32'(trace_id_p) << 8);

    localparam logic [addr_width_p-1:0] first_read_c = addr_width_p'(8);
    localparam logic [addr_width_p-1:0] last_idx_c   = addr_width_p'(24);

    logic [2:0]  word_idx;
    logic [31:0] byte_addr;
    logic [31:0] word_data;
    logic        out_of_range;

    always_comb begin
        word_idx  = 3'd0;
        byte_addr = 32'd0;
        word_data = 32'd0;
        data_o    = {op_done_c, 69'b0};

        // Writes occupy 0..7 (index = addr); read/receive pairs occupy 8..23,
        // two entries per word, so the word index is addr/2 - 4.
        if (addr_i < first_read_c) begin
            word_idx = addr_i[2:0];
        end else begin
            word_idx = addr_i[3:1] - 3'd4;
        end
        byte_addr = base_c + {27'b0, word_idx, 2'b00};
        word_data = tag_c | {29'b0, word_idx};

        if (addr_i < first_read_c) begin
            data_o = {op_send_c, 4'b0, 1'b1, byte_addr, word_data};
        end else if (addr_i < last_idx_c) begin
            if (!addr_i[0]) begin
                data_o = {op_send_c, 4'b0, 1'b0, byte_addr, 32'h0};
            end else begin
                data_o = {op_recv_c, 37'b0, word_data};
            end
        end
        // Index 24 and everything past it return the done entry so a runaway
        // replay node halts instead of issuing stray traffic.
    end

    assign out_of_range = (addr_i > last_idx_c);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            error_o <= 1'b0;
        end else if (out_of_range) begin
            error_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_core_intf_trace_rom.sv
module tb_core_intf_trace_rom;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic [14:0] addr_i = '0;
    logic [72:0] data0, data1, data2;
    logic        err0, err1, err2;

    int checks = 0;
    int passed = 0;
    logic err_exp = 1'b0;

    // Expected trace contents, built entry by entry from the trace rules.
    logic [72:0] exp_tab [3][25];

    always #5 clk = ~clk;

    core_intf_trace_rom #(.width_p(73), .addr_width_p(15), .trace_id_p(0)) u_rom0 (
        .clk_i(clk), .reset_i(reset_i), .addr_i(addr_i), .data_o(data0), .error_o(err0));
    core_intf_trace_rom #(.width_p(73), .addr_width_p(15), .trace_id_p(1)) u_rom1 (
        .clk_i(clk), .reset_i(reset_i), .addr_i(addr_i), .data_o(data1), .error_o(err1));
    core_intf_trace_rom #(.width_p(73), .addr_width_p(15), .trace_id_p(2)) u_rom2 (
        .clk_i(clk), .reset_i(reset_i), .addr_i(addr_i), .data_o(data2), .error_o(err2));

    task automatic chk(input string tag, input logic [72:0] obs, input logic [72:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [72:0] exp_of(input int t, input int a);
        if (a > 24) return {4'h3, 69'b0};
        return exp_tab[t][a];
    endfunction

    // One cycle: check error_o from the previous edge, apply new inputs,
    // check data_o combinationally, then advance the error model.
    task automatic step(input int a, input logic r);
        @(negedge clk);
        chk("err0", {72'b0, err0}, {72'b0, err_exp});
        chk("err1", {72'b0, err1}, {72'b0, err_exp});
        chk("err2", {72'b0, err2}, {72'b0, err_exp});
        addr_i  = 15'(a);
        reset_i = r;
        #1;
        chk("data0", data0, exp_of(0, a));
        chk("data1", data1, exp_of(1, a));
        chk("data2", data2, exp_of(2, a));
        if (r) err_exp = 1'b0;
        else if (a > 24) err_exp = 1'b1;
    endtask

    initial begin
        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < 8; i++) begin
                logic [31:0] ad, d;
                ad = 32'(t * 4096 + 4 * i);
                d  = 32'hC0DE_0000 + 32'(t * 256 + i);
                exp_tab[t][i]         = {4'h1, 4'b0, 1'b1, ad, d};
                exp_tab[t][8 + 2 * i] = {4'h1, 4'b0, 1'b0, ad, 32'h0};
                exp_tab[t][9 + 2 * i] = {4'h2, 37'b0, d};
            end
            exp_tab[t][24] = {4'h3, 69'b0};
        end

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_err0", {72'b0, err0}, 73'd0);
        chk("reset_err1", {72'b0, err1}, 73'd0);
        chk("reset_err2", {72'b0, err2}, 73'd0);
        err_exp = 1'b0;

        // Directed entries with hand-written values
        step(0, 1'b0);
        chk("t0_a0", data0, {4'h1, 4'b0, 1'b1, 32'h0000_0000, 32'hC0DE_0000});
        step(7, 1'b0);
        chk("t0_a7", data0, {4'h1, 4'b0, 1'b1, 32'h0000_001C, 32'hC0DE_0007});
        step(8, 1'b0);
        chk("t1_a8", data1, {4'h1, 5'b0, 32'h0000_1000, 32'h0});
        step(9, 1'b0);
        chk("t1_a9", data1, {4'h2, 37'b0, 32'hC0DE_0100});
        step(23, 1'b0);
        chk("t2_a23", data2, {4'h2, 37'b0, 32'hC0DE_0207});
        step(24, 1'b0);
        chk("t2_a24", data2, {4'h3, 69'b0});

        // Out-of-range fetch: done entry, sticky error, cleared only by reset
        step(25, 1'b0);
        chk("oor_data0", data0, {4'h3, 69'b0});
        step(0, 1'b0);
        chk("oor_err_rise", {72'b0, err1}, 73'd1);
        step(0, 1'b0);
        chk("oor_err_hold", {72'b0, err2}, 73'd1);
        step(0, 1'b1);
        step(0, 1'b0);
        chk("oor_err_clear", {72'b0, err0}, 73'd0);

        // Reset wins over a simultaneous out-of-range address
        step(30, 1'b1);
        step(0, 1'b0);
        chk("reset_wins", {72'b0, err0}, 73'd0);

        // Sweep with reset held: table contents, error held low
        step(31, 1'b0);
        for (int a = 0; a <= 24; a++) step(a, 1'b1);
        step(0, 1'b0);
        chk("sweep_err", {72'b0, err1}, 73'd0);

        // Random addresses with occasional out-of-range fetches and reset pulses
        for (int n = 0; n < 400; n++) begin
            int a;
            logic r;
            if ($urandom_range(0, 9) == 0) a = int'($urandom_range(25, 32767));
            else a = int'($urandom_range(0, 24));
            r = ($urandom_range(0, 15) == 0);
            step(a, r);
        end
        step(0, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
